// File: rtl/dram_arbiter_pkg.sv
// DRAM arbiter shared constants: FSM state encodings and default widths.
// Also used by the optional ARB_LOCK_EN build of dram_arbiter.
package dram_arbiter_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam int DEF_CORES  = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 12;
endpackage

// File: rtl/dram_arbiter_rr_picker.sv
// Combinational round-robin pick: first unmasked requester at or after rr_ptr,
// wrapping modulo CORES. Returns one-hot grant, its index and a found flag.
module dram_arbiter_rr_picker
  import dram_arbiter_pkg::*;
#(
  parameter int CORES = DEF_CORES,
  parameter int PTR_W = $clog2(DEF_CORES)
) (
  input  logic [CORES-1:0] req,
  input  logic [CORES-1:0] mask,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [CORES-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);
  logic [CORES-1:0] elig;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] pos;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    pos  = '0;
    elig = req & ~mask;
    for (int i = 0; i < CORES; i++) begin
      // One extra bit holds rr_ptr+i before the modulo wrap.
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(CORES)) sum = sum - (PTR_W+1)'(CORES);
      pos = sum[PTR_W-1:0];
      if (!any && elig[pos]) begin
        any      = 1'b1;
        idx      = pos;
        gnt[pos] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter serialising CORES cores onto one single-port DRAM.
// Optional ARB_LOCK_EN adds core_lock for atomic back-to-back ownership.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int CORES  = DEF_CORES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CORES-1:0]         core_req,
  input  logic [CORES-1:0]         core_we,
  input  logic [CORES*ADDR_W-1:0]  core_addr,
  input  logic [CORES*DATA_W-1:0]  core_wdata,
`ifdef ARB_LOCK_EN
  input  logic [CORES-1:0]         core_lock,
`endif
  output logic [CORES-1:0]         core_gnt,
  output logic [CORES-1:0]         core_done,
  output logic [DATA_W-1:0]        core_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);
  localparam int PTR_W = $clog2(CORES);
  localparam logic [CORES-1:0] ONE = {{(CORES-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_a  [CORES];
  logic [DATA_W-1:0] wdata_a [CORES];

  for (genvar n = 0; n < CORES; n++) begin : g_unpack
    assign addr_a[n]  = core_addr[n*ADDR_W +: ADDR_W];
    assign wdata_a[n] = core_wdata[n*DATA_W +: DATA_W];
  end

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  win_q, win_d;
  logic [CORES-1:0]  gnt_q, gnt_d;
  logic [CORES-1:0]  done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic              txn_we_q, txn_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef ARB_LOCK_EN
  logic              lock_vld_q, lock_vld_d;
  logic [PTR_W-1:0]  lock_own_q, lock_own_d;
`endif

  logic [CORES-1:0]  pick_mask, pick_gnt;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;

  // A core's request is ignored in its done cycle so a lagging req can't re-win.
  always_comb begin
    pick_mask = done_q;
`ifdef ARB_LOCK_EN
    if (lock_vld_q) pick_mask = ~(ONE << lock_own_q);
`endif
  end

  dram_arbiter_rr_picker #(.CORES(CORES), .PTR_W(PTR_W)) u_picker (
    .req    (core_req),
    .mask   (pick_mask),
    .rr_ptr (ptr_q),
    .gnt    (pick_gnt),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    rdata_d  = rdata_q;
    en_d     = 1'b0;
    we_d     = 1'b0;
    txn_we_d = txn_we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef ARB_LOCK_EN
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef ARB_LOCK_EN
        if (lock_vld_q && !core_req[lock_own_q] && !core_lock[lock_own_q])
          lock_vld_d = 1'b0;
`endif
        if (pick_any) begin
          state_d  = ST_ACCESS;
          win_d    = pick_idx;
          gnt_d    = pick_gnt;
          en_d     = 1'b1;
          we_d     = core_we[pick_idx];
          txn_we_d = core_we[pick_idx];
          addr_d   = addr_a[pick_idx];
          wdata_d  = wdata_a[pick_idx];
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        done_d  = gnt_q;
        // Registered RAM: read data is valid in the cycle after the strobe.
        if (!txn_we_q) rdata_d = mem_rdata;
        ptr_d = (win_q == PTR_W'(CORES-1)) ? '0 : win_q + 1'b1;
`ifdef ARB_LOCK_EN
        if (core_lock[win_q]) begin
          lock_vld_d = 1'b1;
          lock_own_d = win_q;
          ptr_d      = ptr_q;
        end else begin
          lock_vld_d = 1'b0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      txn_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef ARB_LOCK_EN
      lock_vld_q <= 1'b0;
      lock_own_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      en_q     <= en_d;
      we_q     <= we_d;
      txn_we_q <= txn_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
`ifdef ARB_LOCK_EN
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
`endif
    end
  end

  assign core_gnt   = gnt_q;
  assign core_done  = done_q;
  assign core_rdata = rdata_q;
  assign mem_en     = en_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level arbitration model. Lock scenario under ARB_LOCK_EN.
module tb_dram_arbiter;
  localparam int CORES = 4, DATA_W = 16, ADDR_W = 12;

  logic clock, reset, ram_clr;
  logic [CORES-1:0]        core_req, core_we;
  logic [CORES*ADDR_W-1:0] core_addr;
  logic [CORES*DATA_W-1:0] core_wdata;
`ifdef ARB_LOCK_EN
  logic [CORES-1:0]        core_lock;
`endif
  logic [CORES-1:0]  core_gnt, core_done;
  logic [DATA_W-1:0] core_rdata, mem_wdata, mem_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;

  int total, bad, cyc;

  dram_arbiter #(.CORES(CORES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
`ifdef ARB_LOCK_EN
    .core_lock(core_lock),
`endif
    .core_gnt(core_gnt), .core_done(core_done), .core_rdata(core_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [15:0] pat(input logic [11:0] a);
    return {a[7:0], 4'h5, a[11:8]} ^ 16'hA53C;
  endfunction

  // Registered-output RAM; read data is garbage except the cycle after a read strobe.
  logic [15:0] dram [4096];
  always @(posedge clock) begin
    if (ram_clr)
      for (int i = 0; i < 4096; i++) dram[i] <= pat(12'(i));
    else if (mem_en && mem_we)
      dram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= dram[mem_addr];
    else                   mem_rdata <= 16'($urandom);
  end

  logic [15:0] refmem [4096];

  // model state
  int               m_ptr, m_g, m_w;
  bit               m_busy, m_we;
  logic [11:0]      m_addr, e_addr;
  logic [15:0]      m_wdata, m_rdv, e_wdata, e_rdata;
  logic [CORES-1:0] e_gnt, e_done, elig;
  logic             e_en, e_we;
  bit               want [CORES];
  bit               drop_next [CORES];

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic set_core(input int n, input logic req, input logic we,
                          input logic [11:0] a, input logic [15:0] d);
    core_req[n] = req;
    core_we[n]  = we;
    core_addr[n*ADDR_W +: ADDR_W]  = a;
    core_wdata[n*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
`ifdef ARB_LOCK_EN
    core_lock = '0;
`endif
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({core_gnt, core_done, mem_en, mem_we} !== 10'd0) begin
        bad++;
        $display("FAIL reset_ctl: cycle %0d got gnt=%b done=%b en=%b we=%b want all 0",
                 k, core_gnt, core_done, mem_en, mem_we);
      end
      total++;
      if ({mem_addr, mem_wdata, core_rdata} !== 44'd0) begin
        bad++;
        $display("FAIL reset_data: cycle %0d got addr=%h wdata=%h rdata=%h want 0",
                 k, mem_addr, mem_wdata, core_rdata);
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    do_reset();
    set_core(0, 1'b1, 1'b1, 12'd5, 16'h00AB);
    tick();
    total++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, core_gnt} !== {1'b1, 1'b1, 12'd5, 16'h00AB, 4'b0001}) begin
      bad++;
      $display("FAIL wr_access: got en=%b we=%b addr=%h wdata=%h gnt=%b want 1 1 005 00ab 0001",
               mem_en, mem_we, mem_addr, mem_wdata, core_gnt);
    end
    tick();
    total++;
    if ({mem_en, mem_we, core_gnt, core_done, mem_addr} !== {2'b00, 4'b0001, 4'b0000, 12'd5}) begin
      bad++;
      $display("FAIL wr_resp: got en=%b we=%b gnt=%b done=%b addr=%h want 0 0 0001 0000 005",
               mem_en, mem_we, core_gnt, core_done, mem_addr);
    end
    tick();
    total++;
    if ({core_done, core_gnt, core_rdata} !== {4'b0001, 4'b0000, 16'h0000}) begin
      bad++;
      $display("FAIL wr_done: got done=%b gnt=%b rdata=%h want 0001 0000 0000",
               core_done, core_gnt, core_rdata);
    end
    core_req[0] = 1'b0;
    tick();
    tick();
    set_core(0, 1'b1, 1'b0, 12'd5, 16'hFFFF);
    tick(); tick(); tick();
    total++;
    if ({core_done, core_rdata} !== {4'b0001, 16'h00AB}) begin
      bad++;
      $display("FAIL rd_back: got done=%b rdata=%h want 0001 00ab", core_done, core_rdata);
    end
    core_req[0] = 1'b0;
    tick();
  endtask

  task automatic test_all_four();
    logic [CORES-1:0] eg, ed;
    do_reset();
    for (int n = 0; n < CORES; n++) set_core(n, 1'b1, 1'b0, 12'(100 + n), 16'h0);
    for (int t = 1; t <= 3*CORES; t++) begin
      int k, ph;
      tick();
      k = (t - 1) / 3;
      ph = (t - 1) % 3;
      eg = '0; ed = '0;
      if (ph < 2) eg[k] = 1'b1; else ed[k] = 1'b1;
      total++;
      if ({core_gnt, core_done, mem_en} !== {eg, ed, ph == 0}) begin
        bad++;
        $display("FAIL all4_seq: t=%0d got gnt=%b done=%b en=%b want %b %b %b",
                 t, core_gnt, core_done, mem_en, eg, ed, ph == 0);
      end
      if (ph == 0) begin
        total++;
        if (mem_addr !== 12'(100 + k)) begin
          bad++;
          $display("FAIL all4_addr: t=%0d got %h want %h", t, mem_addr, 12'(100 + k));
        end
      end
      if (ph == 2) begin
        total++;
        if (core_rdata !== pat(12'(100 + k))) begin
          bad++;
          $display("FAIL all4_rdata: core %0d got %h want %h", k, core_rdata, pat(12'(100 + k)));
        end
        core_req[k] = 1'b0;
      end
    end
  endtask

  task automatic test_hold_vs_once();
    do_reset();
    set_core(2, 1'b1, 1'b0, 12'd200, 16'h0);
    tick();
    total++;
    if (core_gnt !== 4'b0100) begin
      bad++; $display("FAIL hold_g1: got gnt=%b want 0100", core_gnt);
    end
    set_core(1, 1'b1, 1'b0, 12'd201, 16'h0);
    tick(); tick();
    total++;
    if (core_done !== 4'b0100) begin
      bad++; $display("FAIL hold_d1: got done=%b want 0100", core_done);
    end
    tick();
    total++;
    if (core_gnt !== 4'b0010) begin
      bad++; $display("FAIL hold_g2: got gnt=%b want 0010", core_gnt);
    end
    tick(); tick();
    total++;
    if (core_done !== 4'b0010) begin
      bad++; $display("FAIL hold_d2: got done=%b want 0010", core_done);
    end
    core_req[1] = 1'b0;
    tick();
    total++;
    if (core_gnt !== 4'b0100) begin
      bad++; $display("FAIL hold_g3: got gnt=%b want 0100", core_gnt);
    end
    core_req[2] = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    set_core(3, 1'b1, 1'b1, 12'd30, 16'h1234);
    tick();
    total++;
    if ({core_gnt, mem_en} !== {4'b1000, 1'b1}) begin
      bad++; $display("FAIL rst_acc: got gnt=%b en=%b want 1000 1", core_gnt, mem_en);
    end
    reset = 1'b1;
    tick();
    total++;
    if ({core_gnt, core_done, mem_en, mem_we, mem_addr, mem_wdata, core_rdata} !== 54'd0) begin
      bad++;
      $display("FAIL rst_clear: got gnt=%b done=%b en=%b we=%b addr=%h wdata=%h rdata=%h want 0",
               core_gnt, core_done, mem_en, mem_we, mem_addr, mem_wdata, core_rdata);
    end
    reset = 1'b0;
    set_core(1, 1'b1, 1'b0, 12'd300, 16'h0);
    tick();
    total++;
    if ({core_done, core_gnt} !== {4'b0000, 4'b0010}) begin
      bad++; $display("FAIL rst_order: got done=%b gnt=%b want 0000 0010", core_done, core_gnt);
    end
    tick(); tick();
    total++;
    if (core_done !== 4'b0010) begin
      bad++; $display("FAIL rst_d1: got done=%b want 0010", core_done);
    end
    core_req[1] = 1'b0;
    tick();
    total++;
    if ({core_gnt, mem_we, mem_addr, mem_wdata} !== {4'b1000, 1'b1, 12'd30, 16'h1234}) begin
      bad++;
      $display("FAIL rst_regrant: got gnt=%b we=%b addr=%h wdata=%h want 1000 1 01e 1234",
               core_gnt, mem_we, mem_addr, mem_wdata);
    end
    tick(); tick();
    total++;
    if (core_done !== 4'b1000) begin
      bad++; $display("FAIL rst_d3: got done=%b want 1000", core_done);
    end
    core_req[3] = 1'b0;
    tick();
  endtask

  task automatic test_drop_in_done();
    do_reset();
    set_core(0, 1'b1, 1'b0, 12'd400, 16'h0);
    tick(); tick(); tick();
    total++;
    if (core_done !== 4'b0001) begin
      bad++; $display("FAIL drop_done: got done=%b want 0001", core_done);
    end
    // req still high through the done cycle; it must not win again
    tick();
    core_req[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({core_gnt, core_done, mem_en} !== 9'd0) begin
        bad++;
        $display("FAIL drop_idle: cycle %0d got gnt=%b done=%b en=%b want 0",
                 k, core_gnt, core_done, mem_en);
      end
      tick();
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    set_core(1, 1'b1, 1'b0, 12'd40, 16'h0);
    core_lock[1] = 1'b1;
    tick();
    set_core(0, 1'b1, 1'b0, 12'd41, 16'h0);
    total++;
    if (core_gnt !== 4'b0010) begin
      bad++; $display("FAIL lock_g1: got gnt=%b want 0010", core_gnt);
    end
    tick(); tick();
    total++;
    if ({core_done, core_rdata} !== {4'b0010, pat(12'd40)}) begin
      bad++; $display("FAIL lock_d1: got done=%b rdata=%h want 0010 %h", core_done, core_rdata, pat(12'd40));
    end
    set_core(1, 1'b1, 1'b1, 12'd40, 16'hBEEF);
    core_lock[1] = 1'b0;
    tick();
    total++;
    if ({core_gnt, mem_we, mem_wdata} !== {4'b0010, 1'b1, 16'hBEEF}) begin
      bad++; $display("FAIL lock_g2: got gnt=%b we=%b wdata=%h want 0010 1 beef", core_gnt, mem_we, mem_wdata);
    end
    tick(); tick();
    total++;
    if (core_done !== 4'b0010) begin
      bad++; $display("FAIL lock_d2: got done=%b want 0010", core_done);
    end
    core_req[1] = 1'b0;
    tick();
    total++;
    if (core_gnt !== 4'b0001) begin
      bad++; $display("FAIL lock_g3: got gnt=%b want 0001", core_gnt);
    end
    core_req[0] = 1'b0;
    tick(); tick(); tick();
  endtask
`endif

  task automatic test_random();
    do_reset();
    m_ptr = 0; m_busy = 1'b0; m_g = 0; m_w = 0; m_we = 1'b0;
    e_addr = '0; e_wdata = '0; e_rdata = '0;
    for (int n = 0; n < CORES; n++) begin want[n] = 1'b0; drop_next[n] = 1'b0; end
    repeat (1500) begin
      tick();
      e_gnt = '0; e_done = '0; e_en = 1'b0; e_we = 1'b0;
      if (m_busy) begin
        if (cyc == m_g) begin
          e_gnt[m_w] = 1'b1; e_en = 1'b1; e_we = m_we; e_addr = m_addr; e_wdata = m_wdata;
        end else if (cyc == m_g + 1) begin
          e_gnt[m_w] = 1'b1;
        end else begin
          e_done[m_w] = 1'b1;
          if (!m_we) e_rdata = m_rdv;
          m_busy = 1'b0;
        end
      end
      total++;
      if ({core_gnt, core_done, mem_en, mem_we} !== {e_gnt, e_done, e_en, e_we}) begin
        bad++;
        $display("FAIL rnd_ctl: cyc %0d got gnt=%b done=%b en=%b we=%b want %b %b %b %b",
                 cyc, core_gnt, core_done, mem_en, mem_we, e_gnt, e_done, e_en, e_we);
      end
      total++;
      if ({mem_addr, mem_wdata, core_rdata} !== {e_addr, e_wdata, e_rdata}) begin
        bad++;
        $display("FAIL rnd_data: cyc %0d got addr=%h wdata=%h rdata=%h want %h %h %h",
                 cyc, mem_addr, mem_wdata, core_rdata, e_addr, e_wdata, e_rdata);
      end
      // core agents: hold req until done is seen, then drop one cycle later
      for (int n = 0; n < CORES; n++) begin
        if (drop_next[n]) begin
          want[n] = 1'b0; drop_next[n] = 1'b0;
        end else if (e_done[n]) begin
          drop_next[n] = 1'b1;
        end else if (m_busy && m_w == n) begin
          if ($urandom_range(9) == 0) want[n] = 1'b0;
          set_core(n, want[n], 1'($urandom), 12'($urandom), 16'($urandom));
        end else if (!want[n]) begin
          if ($urandom_range(3) == 0) begin
            want[n] = 1'b1;
            set_core(n, 1'b1, 1'($urandom), 12'(64 + $urandom_range(15)), 16'($urandom));
          end else begin
            set_core(n, 1'b0, 1'($urandom), 12'($urandom), 16'($urandom));
          end
        end
        core_req[n] = want[n];
      end
      if ($urandom_range(79) == 0) begin
        reset = 1'b1;
        m_busy = 1'b0; m_ptr = 0;
        e_addr = '0; e_wdata = '0; e_rdata = '0;
      end else begin
        reset = 1'b0;
        if (!m_busy) begin
          elig = core_req & ~e_done;
          for (int i = 0; i < CORES; i++) begin
            int n;
            n = (m_ptr + i) % CORES;
            if (!m_busy && elig[n]) begin
              m_busy = 1'b1; m_w = n; m_g = cyc + 1;
              m_we = core_we[n];
              m_addr = core_addr[n*ADDR_W +: ADDR_W];
              m_wdata = core_wdata[n*DATA_W +: DATA_W];
              if (m_we) refmem[m_addr] = m_wdata;
              else      m_rdv = refmem[m_addr];
              m_ptr = (n + 1) % CORES;
            end
          end
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    ram_clr = 1'b1;
    for (int i = 0; i < 4096; i++) refmem[i] = pat(12'(i));
    do_reset();
    ram_clr = 1'b0;
    test_reset();
    test_write_read();
    test_all_four();
    test_hold_vs_once();
    test_reset_mid_access();
    test_drop_in_done();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    for (int i = 0; i < 4096; i++) refmem[i] = dut_free_copy(i);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Directed tests only wrote addresses outside the random window, so the
  // random model starts from the known initial image.
  function automatic logic [15:0] dut_free_copy(input int i);
    if (i == 5)  return 16'h00AB;
    if (i == 30) return 16'h1234;
`ifdef ARB_LOCK_EN
    if (i == 40) return 16'hBEEF;
`endif
    return pat(12'(i));
  endfunction
endmodule
